// File: rtl/ps2_mouse_encoder.sv
// PS/2 mouse report encoder: accumulates motion and button state,
// emits 3-byte reports on a toggle-strobe 25-bit bus at a fixed interval.
module ps2_mouse_encoder #(
  parameter int RATE_DIV = 500000,
  parameter int ACC_W    = 12
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mv_valid,
  input  logic [8:0]  mv_dx,
  input  logic [8:0]  mv_dy,
  input  logic [2:0]  btn,
  output logic [24:0] ps2_mouse,
  output logic        pkt_sent,
  output logic        acc_sat
);

  localparam int CW = $clog2(RATE_DIV);
  localparam int EW = ACC_W + 2;
  localparam logic [CW-1:0] RELOAD = CW'(RATE_DIV - 1);
  localparam logic signed [EW-1:0] MAXV = EW'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;
  localparam logic signed [ACC_W-1:0] P255 = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] N256 = ACC_W'(-256);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_BUILD = 2'd1,
    S_EMIT  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_x_q, acc_x_d;
  logic signed [ACC_W-1:0]  acc_y_q, acc_y_d;
  logic                     acc_sat_q, acc_sat_d;
  logic [2:0]               btn_last_q, btn_last_d;
  logic [2:0]               btn_s_q, btn_s_d;
  logic [8:0]               send_x_q, send_x_d;
  logic [8:0]               send_y_q, send_y_d;
  logic                     ovf_x_q, ovf_x_d;
  logic                     ovf_y_q, ovf_y_d;
  logic [24:0]              ps2_q, ps2_d;
  logic                     pkt_q, pkt_d;

  logic signed [EW-1:0]     sum_x, sum_y;
  logic [ACC_W:0]           sat_x, sat_y;
  logic [8:0]               clp_x, clp_y;

  function automatic logic [8:0] clamp9(
    input logic signed [ACC_W-1:0] a
  );
    if (a > P255) return 9'h0FF;
    else if (a < N256) return 9'h100;
    else return a[8:0];
  endfunction

  // Returns {saturated, value}
  function automatic logic [ACC_W:0] sat_acc(
    input logic signed [EW-1:0] v
  );
    if (v > MAXV) return {1'b1, MAXV[ACC_W-1:0]};
    else if (v < MINV) return {1'b1, MINV[ACC_W-1:0]};
    else return {1'b0, v[ACC_W-1:0]};
  endfunction

  // Drain the sent amount in EMIT while still absorbing new motion.
  always_comb begin
    sum_x = {{2{acc_x_q[ACC_W-1]}}, acc_x_q};
    sum_y = {{2{acc_y_q[ACC_W-1]}}, acc_y_q};
    if (state_q == S_EMIT) begin
      sum_x = sum_x - {{(EW-9){send_x_q[8]}}, send_x_q};
      sum_y = sum_y - {{(EW-9){send_y_q[8]}}, send_y_q};
    end
    if (mv_valid) begin
      sum_x = sum_x + {{(EW-9){mv_dx[8]}}, mv_dx};
      sum_y = sum_y + {{(EW-9){mv_dy[8]}}, mv_dy};
    end
    sat_x = sat_acc(sum_x);
    sat_y = sat_acc(sum_y);
    clp_x = clamp9(acc_x_q);
    clp_y = clamp9(acc_y_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    acc_sat_d  = acc_sat_q;
    btn_last_d = btn_last_q;
    btn_s_d    = btn_s_q;
    send_x_d   = send_x_q;
    send_y_d   = send_y_q;
    ovf_x_d    = ovf_x_q;
    ovf_y_d    = ovf_y_q;
    ps2_d      = ps2_q;
    pkt_d      = 1'b0;
    if (!enable) begin
      state_d    = S_WAIT;
      cnt_d      = RELOAD;
      acc_x_d    = '0;
      acc_y_d    = '0;
      acc_sat_d  = 1'b0;
      btn_last_d = '0;
    end else begin
      acc_x_d   = sat_x[ACC_W-1:0];
      acc_y_d   = sat_y[ACC_W-1:0];
      acc_sat_d = acc_sat_q | sat_x[ACC_W] | sat_y[ACC_W];
      unique case (state_q)
        S_WAIT: begin
          if (cnt_q == '0) begin
            cnt_d = RELOAD;
            if (acc_x_q != '0 || acc_y_q != '0 ||
                btn != btn_last_q)
              state_d = S_BUILD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_BUILD: begin
          cnt_d    = RELOAD;
          send_x_d = clp_x;
          send_y_d = clp_y;
          ovf_x_d  = acc_x_q != {{(ACC_W-9){clp_x[8]}}, clp_x};
          ovf_y_d  = acc_y_q != {{(ACC_W-9){clp_y[8]}}, clp_y};
          btn_s_d  = btn;
          state_d  = S_EMIT;
        end
        S_EMIT: begin
          cnt_d      = RELOAD;
          ps2_d      = {~ps2_q[24], send_y_q[7:0], send_x_q[7:0],
                        ovf_y_q, ovf_x_q, send_y_q[8], send_x_q[8],
                        1'b1, btn_s_q};
          pkt_d      = 1'b1;
          btn_last_d = btn_s_q;
          state_d    = S_WAIT;
        end
        default: begin
          cnt_d   = RELOAD;
          state_d = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT;
      cnt_q      <= RELOAD;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_sat_q  <= 1'b0;
      btn_last_q <= '0;
      btn_s_q    <= '0;
      send_x_q   <= '0;
      send_y_q   <= '0;
      ovf_x_q    <= 1'b0;
      ovf_y_q    <= 1'b0;
      ps2_q      <= '0;
      pkt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_sat_q  <= acc_sat_d;
      btn_last_q <= btn_last_d;
      btn_s_q    <= btn_s_d;
      send_x_q   <= send_x_d;
      send_y_q   <= send_y_d;
      ovf_x_q    <= ovf_x_d;
      ovf_y_q    <= ovf_y_d;
      ps2_q      <= ps2_d;
      pkt_q      <= pkt_d;
    end
  end

  assign ps2_mouse = ps2_q;
  assign pkt_sent  = pkt_q;
  assign acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_ps2_mouse_encoder.sv
// Scoreboard bench for ps2_mouse_encoder: expected reports are queued
// when motion is driven and checked as each strobe toggle appears.
module tb_ps2_mouse_encoder;

  localparam int RD = 16;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mv_valid = 1'b0;
  logic [8:0]  dx = '0;
  logic [8:0]  dy = '0;
  logic [2:0]  btn = '0;
  logic [24:0] ps2;
  logic        pkt_sent;
  logic        acc_sat;

  int          n_tests = 0;
  int          n_fail = 0;
  int          pkt_cnt = 0;
  bit          sb_on = 1'b0;
  logic        exp_strb = 1'b0;
  logic [23:0] exp_q[$];

  ps2_mouse_encoder #(.RATE_DIV(RD), .ACC_W(AW)) dut (
    .clk_sys  (clk),
    .reset_n  (rst_n),
    .enable   (en),
    .mv_valid (mv_valid),
    .mv_dx    (dx),
    .mv_dy    (dy),
    .btn      (btn),
    .ps2_mouse(ps2),
    .pkt_sent (pkt_sent),
    .acc_sat  (acc_sat)
  );

  always #5 clk = ~clk;

  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_strb = 1'b0;
      end else if (pkt_sent) begin
        pkt_cnt++;
        exp_strb = ~exp_strb;
        n_tests++;
        if (ps2[24] !== exp_strb) begin
          n_fail++;
          $display("FAIL strobe: got %b want %b", ps2[24], exp_strb);
        end
        if (sb_on) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pkt: got %h want none", ps2[23:0]);
          end else begin
            e = exp_q.pop_front();
            if (ps2[23:0] !== e) begin
              n_fail++;
              $display("FAIL packet: got %h want %h", ps2[23:0], e);
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resync();
    en = 1'b0;
    cyc(2);
    en = 1'b1;
  endtask

  task automatic pulse(input int vx, input int vy, input int n);
    mv_valid = 1'b1;
    dx = 9'(vx);
    dy = 9'(vy);
    cyc(n);
    mv_valid = 1'b0;
    dx = '0;
    dy = '0;
  endtask

  // Reference drain: each report carries at most 255/-256 per axis.
  task automatic expect_motion(input int tx, input int ty,
                               input logic [2:0] b,
                               input logic [2:0] bprev);
    int rx, ry, sx, sy;
    logic [2:0] last;
    logic [7:0] st;
    rx = tx;
    ry = ty;
    last = bprev;
    while (rx != 0 || ry != 0 || b != last) begin
      sx = (rx > 255) ? 255 : (rx < -256) ? -256 : rx;
      sy = (ry > 255) ? 255 : (ry < -256) ? -256 : ry;
      st = {ry != sy, rx != sx, sy < 0, sx < 0, 1'b1, b};
      exp_q.push_back({sy[7:0], sx[7:0], st});
      rx -= sx;
      ry -= sy;
      last = b;
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      cyc(1);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
    cyc(3 * (RD + 2));
  endtask

  task automatic wait_state(input logic [1:0] s, output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (k < 100 && !ok) begin
      cyc(1);
      if (dut.state_q == s) ok = 1'b1;
      k++;
    end
  endtask

  task automatic test_reset();
    cyc(3);
    n_tests++;
    if (ps2 !== 25'd0 || pkt_sent !== 1'b0 || acc_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: got %h/%b/%b want 0/0/0",
               ps2, pkt_sent, acc_sat);
    end
    rst_n = 1'b1;
    en = 1'b1;
    sb_on = 1'b1;
    cyc(100);
    n_tests++;
    if (ps2 !== 25'd0 || pkt_cnt != 0) begin
      n_fail++;
      $display("FAIL idle: got %h pkts %0d want 0 pkts 0", ps2, pkt_cnt);
    end
  endtask

  task automatic test_small_motion();
    resync();
    expect_motion(5, -3, 3'b000, 3'b000);
    pulse(5, -3, 1);
    wait_drain("small");
  endtask

  task automatic test_large_motion();
    resync();
    expect_motion(800, 0, 3'b000, 3'b000);
    pulse(200, 0, 4);
    wait_drain("large");
  endtask

  task automatic test_buttons();
    btn = 3'b000;
    resync();
    btn = 3'b001;
    expect_motion(0, 0, 3'b001, 3'b000);
    wait_drain("press");
    btn = 3'b000;
    expect_motion(0, 0, 3'b000, 3'b001);
    wait_drain("release");
  endtask

  task automatic test_back_to_back();
    btn = 3'b000;
    resync();
    btn = 3'b010;
    expect_motion(-300, 100, 3'b010, 3'b000);
    pulse(-150, 50, 2);
    wait_drain("b2b");
    btn = 3'b000;
    expect_motion(0, 0, 3'b000, 3'b010);
    wait_drain("b2b_rel");
  endtask

  task automatic test_saturation();
    logic [24:0] hold;
    int c0;
    sb_on = 1'b0;
    resync();
    pulse(255, 0, 30);
    n_tests++;
    if (acc_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_flag: got %b want 1", acc_sat);
    end
    n_tests++;
    if (dut.acc_x_q !== 12'sd2047) begin
      n_fail++;
      $display("FAIL sat_acc: got %0d want 2047", dut.acc_x_q);
    end
    en = 1'b0;
    cyc(1);
    hold = ps2;
    c0 = pkt_cnt;
    n_tests++;
    if (acc_sat !== 1'b0 || dut.acc_x_q !== 12'sd0) begin
      n_fail++;
      $display("FAIL sat_clear: got %b/%0d want 0/0", acc_sat, dut.acc_x_q);
    end
    cyc(40);
    n_tests++;
    if (pkt_cnt != c0 || ps2 !== hold) begin
      n_fail++;
      $display("FAIL disabled: got pkts %0d ps2 %h want %0d %h",
               pkt_cnt - c0, ps2, 0, hold);
    end
    resync();
    sb_on = 1'b1;
    cyc(3 * (RD + 2));
  endtask

  task automatic test_abandon();
    bit ok;
    int c0;
    resync();
    pulse(9, 0, 1);
    wait_state(2'd1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abandon_build: got timeout want BUILD");
    end
    en = 1'b0;
    cyc(1);
    c0 = pkt_cnt;
    en = 1'b1;
    cyc(3 * (RD + 2));
    n_tests++;
    if (pkt_cnt != c0) begin
      n_fail++;
      $display("FAIL abandon: got %0d pkts want 0", pkt_cnt - c0);
    end
  endtask

  task automatic test_reset_in_emit();
    bit ok;
    sb_on = 1'b0;
    resync();
    pulse(7, 0, 1);
    wait_state(2'd2, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_emit_reach: got timeout want EMIT");
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (ps2 !== 25'd0 || pkt_sent !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_emit: got %h/%b want 0/0", ps2, pkt_sent);
    end
    cyc(2);
    rst_n = 1'b1;
    sb_on = 1'b1;
    resync();
    expect_motion(7, 0, 3'b000, 3'b000);
    pulse(7, 0, 1);
    wait_drain("post_rst");
    n_tests++;
    if (ps2[24] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_toggle: got %b want 1", ps2[24]);
    end
  endtask

  initial begin
    test_reset();
    test_small_motion();
    test_large_motion();
    test_buttons();
    test_back_to_back();
    test_saturation();
    test_abandon();
    test_reset_in_emit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
